// File: rtl/qei_pkg.sv
// rtl/qei_pkg.sv - shared types and helpers for the quadrature encoder front end
package qei_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESYNC = 2'd2
  } qei_state_e;

  localparam logic signed [1:0] STEP_NONE = 2'sb00;
  localparam logic signed [1:0] STEP_FWD  = 2'sb01;
  localparam logic signed [1:0] STEP_REV  = 2'sb11;

  // Forward successor in the Gray sequence 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] gray_next(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Signed clamp to the range of a (w+1)-bit two's complement value.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< w) - 64'sd1;
    lo = -(64'sd1 <<< w);
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/qei_debounce.sv
// rtl/qei_debounce.sv - two-flop synchroniser plus stable-count filter for one encoder pin
module qei_debounce #(
  parameter int FILT = 3
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  logic bypass_i,
  input  logic pin_i,
  output logic filt_o
);

  localparam int CW = $clog2(FILT + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      if (bypass_i) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT - 1)) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/qei_error.sv
// rtl/qei_error.sv - quadrature decode, position counter and saturated position error
module qei_error #(
  parameter int W    = 11,
  parameter int PW   = 15,
  parameter int FILT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enc_a,
  input  logic                enc_b,
  input  logic                zero_pos,
  input  logic                clr_err,
  input  logic signed [PW:0]  setpoint,
  output logic signed [PW:0]  position,
  output logic signed [W:0]   e_out,
  output logic                sat,
  output logic                dir,
  output logic                qerr
);

  import qei_pkg::*;

  localparam int WCW = $clog2(FILT + 2);

  qei_state_e          state_q, state_d;
  logic [WCW-1:0]      wait_q, wait_d;
  logic [1:0]          prev_q, prev_d;
  logic signed [PW:0]  pos_q, pos_d;
  logic                dir_q, dir_d;
  logic                qerr_q, qerr_d;
  logic signed [W:0]   e_q, e_d;
  logic                sat_q, sat_d;

  logic                filt_a, filt_b;
  logic [1:0]          ab;
  logic signed [1:0]   step;
  logic                illegal;
  logic signed [PW+1:0] diff;
  logic signed [63:0]  diff64, clamped;

  qei_debounce #(.FILT(FILT)) u_deb_a (
    .clk_i(clk), .resetn_i(reset), .bypass_i(state_q == ST_INIT), .pin_i(enc_a), .filt_o(filt_a)
  );
  qei_debounce #(.FILT(FILT)) u_deb_b (
    .clk_i(clk), .resetn_i(reset), .bypass_i(state_q == ST_INIT), .pin_i(enc_b), .filt_o(filt_b)
  );

  assign ab = {filt_a, filt_b};

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    prev_d  = prev_q;
    step    = STEP_NONE;
    illegal = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (wait_q == WCW'(FILT + 1)) begin
          prev_d  = ab;
          wait_d  = '0;
          state_d = ST_RUN;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      ST_RUN: begin
        prev_d = ab;
        if ((ab ^ prev_q) == 2'b11) begin
          illegal = 1'b1;
          state_d = ST_RESYNC;
        end else if (ab == gray_next(prev_q)) begin
          step = STEP_FWD;
        end else if (ab != prev_q) begin
          step = STEP_REV;
        end
      end
      ST_RESYNC: begin
        prev_d  = ab;
        state_d = ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // zero_pos drops any step in the same cycle, including its direction update.
  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    qerr_d = qerr_q;
    if (zero_pos) begin
      pos_d = '0;
    end else if (step != STEP_NONE) begin
      pos_d = pos_q + (PW+1)'(step);
      dir_d = (step == STEP_FWD);
    end
    if (illegal)      qerr_d = 1'b1;
    else if (clr_err) qerr_d = 1'b0;
  end

  always_comb begin
    diff    = (PW+2)'(setpoint) - (PW+2)'(pos_q);
    diff64  = 64'(diff);
    clamped = sat_clamp(diff64, W);
    e_d     = clamped[W:0];
    sat_d   = (clamped != diff64);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_INIT;
      wait_q  <= '0;
      prev_q  <= 2'b00;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      qerr_q  <= 1'b0;
      e_q     <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      prev_q  <= prev_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      qerr_q  <= qerr_d;
      e_q     <= e_d;
      sat_q   <= sat_d;
    end
  end

  assign position = pos_q;
  assign e_out    = e_q;
  assign sat      = sat_q;
  assign dir      = dir_q;
  assign qerr     = qerr_q;

endmodule

// File: doc/qei_error.md
Name: qei_error

Overview:
Quadrature encoder front end for the motor position loop. Synchronises and debounces the raw encoder A/B pins, decodes them into a signed position counter, and produces the registered, saturated position error (setpoint - position). The error output drives the PID stage's signed error input directly, one sample per clk.

Parameters:
W, 11, error bit width - 1; e_out is W+1 bits signed, matching the PID error input.
PW, 15, position bit width - 1; position and setpoint are PW+1 bits signed, with PW >= W.
FILT, 3, debounce depth: consecutive stable cycles required before a pin change is accepted; must be >= 1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enc_a  in  1  raw encoder channel A, asynchronous to clk
enc_b  in  1  raw encoder channel B, asynchronous to clk
zero_pos  in  1  synchronous clear of the position counter
clr_err  in  1  clears sticky qerr
setpoint  in  PW+1  signed target position, sampled every cycle
position  out  PW+1  signed decoded position count
e_out  out  W+1  signed saturated error to the PID stage
sat  out  1  high when e_out is clamped this cycle
dir  out  1  direction of last valid step: 1 = forward, 0 = reverse
qerr  out  1  sticky illegal-transition flag

Behaviour:
- Reset:
  - Checked only on the clk rising edge while reset==0.
  - position, e_out, sat, dir, qerr, filter counters, prev_ab and filt_ab all go to 0.
  - FSM goes to INIT.
  - Asserting reset mid-operation discards all state on that edge, including any in-flight filter count.
- Sync: a 2-FF synchroniser on each of enc_a and enc_b (sync1 -> sync2).
- Debounce, per channel:
  - Counter cnt of ceil(log2(FILT+1)) bits.
  - If sync2 == filt: cnt <= 0.
  - Otherwise, if cnt == FILT-1: filt <= sync2 and cnt <= 0; else cnt <= cnt+1.
  - A glitch shorter than FILT cycles never reaches filt.
- FSM, 3 states:
  - INIT: filt bypasses the debounce (filt <= sync2) and there is no counting. Waits 2+FILT cycles via a wait counter, then prev_ab <= filt_ab and the FSM goes to RUN.
  - RUN: decode every cycle. Any illegal transition moves to RESYNC.
  - RESYNC: prev_ab <= filt_ab with no count, then back to RUN on the next cycle. It exists so one illegal step does not cascade into further errors.
- Decode in RUN, with ab = {filt_a, filt_b} compared against prev_ab:
  - Forward (+1): 00->01, 01->11, 11->10, 10->00. Sets dir=1.
  - Reverse (-1): the opposite order. Sets dir=0.
  - Equal: no change.
  - Both bits changed: illegal. Position is unchanged, qerr <= 1, FSM -> RESYNC.
  - prev_ab <= ab every RUN cycle.
- Position:
  - PW+1 bit two's complement; wraps silently.
  - +1 from 2^PW-1 gives -2^PW; -1 from -2^PW gives 2^PW-1.
  - zero_pos has priority over a step in the same cycle: position <= 0 and the step is dropped. zero_pos acts in every FSM state.
- qerr: set wins over clr_err when both occur in the same cycle. Cleared otherwise by clr_err or reset.
- Error path:
  - diff = setpoint - position, computed in PW+2 bits (no overflow).
  - e_out <= clamp(diff, -2^W, 2^W-1), registered.
  - sat <= 1 when the clamp is active.
  - e_out uses the registered position, so it lags position by 1 cycle.
- Latency, from first clk edge sampling a clean pin change (edge k):
  - filt updates at edge k+1+FILT.
  - position updates at edge k+2+FILT.
  - e_out updates at edge k+3+FILT.
  - With FILT=3: position at k+5, e_out at k+6.
- Changes on both pins accepted by the filters on the same edge count as illegal.

Decomposition:
- Shared package (qei_pkg):
  - FSM state enum: INIT, RUN, RESYNC.
  - Forward/reverse step encoding constants.
  - A saturate function (signed clamp from N to W+1 bits), reused by the PID output stage.
- One natural sub-module: qei_debounce, holding the synchroniser plus the debounce counter for a single channel, instantiated twice.
- FSM, decode, position counter and error/saturation logic stay in qei_error.

Test Plan:
- Reset with enc_a=1, enc_b=1 held, FILT=3:
  - All outputs are 0 after reset.
  - INIT exits after 5 cycles with prev_ab=11.
  - position stays 0; no spurious count.
- 8 forward Gray steps (00,01,11,10,...) each held 10 cycles, setpoint=0:
  - position=8, dir=1.
  - e_out=-8 exactly 6 cycles after the final pin edge.
- 2-cycle pulse on enc_a while B is static:
  - position unchanged, qerr=0.
  - The filter counter returns to 0.
- Forced 00->11 jump:
  - qerr=1, position unchanged, FSM passes through RESYNC.
  - A next legal step counts normally.
  - clr_err pulse clears qerr.
- position=-100 reached via reverse steps, setpoint=5000, W=11:
  - diff=5100 clamps to e_out=2047, sat=1.
  - With setpoint=-3000: e_out=-2048, sat=1.
  - With setpoint=0: e_out=100, sat=0.
- position=32767 (preloaded by stepping), then one forward step together with zero_pos:
  - position=0 (zero_pos wins).
  - Repeat without zero_pos: position=-32768.
- Assert reset mid-step while a filter count is in progress:
  - All outputs are 0 on the next edge and the FSM is in INIT.
